multi_pass_counter: RTL
=======================

Name: multi_pass_counter

Overview:
Parametrised multi-pass sequence counter. It runs a COUNT value from a start value to an end value, repeats that PASSES times, then parks in a sticky DONE state.
Generalises the fixed 0..7 x3 sequencer in three ways: configurable width, terminal value and pass count; up/down direction; and start, pause and clear controls.
Feeds sequencing and status logic in the FSM project datapath.

Parameters:
WIDTH, 3, bit width of count; MAX_VAL must be < 2**WIDTH
MAX_VAL, 7, terminal value of one pass (range 0..MAX_VAL)
PASSES, 3, passes per run; must be >= 1
PASS_W, 2, width of pass_idx; must satisfy 2**PASS_W >= PASSES

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  begin a run; sampled in IDLE/DONE only
clr  input  1  synchronous abort to IDLE; priority over start/pause
pause  input  1  freeze advance while high in RUN
dir  input  1  0 = up (0..MAX_VAL), 1 = down (MAX_VAL..0); latched on start
count  output  WIDTH  current count value
pass_idx  output  PASS_W  current pass, 0-based
wrap  output  1  one-cycle pulse on each pass boundary
busy  output  1  high while in RUN
done  output  1  sticky run-complete flag

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, pass_idx=0, wrap=0, busy=0, done=0, latched dir=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- Start value and end value depend on the latched direction:
  - dir=0: start value SV=0, end value EV=MAX_VAL.
  - dir=1: SV=MAX_VAL, EV=0.
- Per-edge priority: rst, then clr, then start, then pause, then advance.
- clr high in any state: next state IDLE; count=0, pass_idx=0, done=0, wrap=0, busy=0.
- IDLE or DONE with start=1 (and clr=0):
  - latch dir; count=SV, pass_idx=0, done=0, busy=1; next state RUN.
  - pause on this same edge is ignored.
- IDLE with start=0: hold all values.
- RUN, start is ignored.
- RUN with pause=1: hold count and pass_idx; wrap=0.
- RUN with pause=0:
  - count != EV: count steps by +1 (dir=0) or -1 (dir=1); wrap=0.
  - count == EV and pass_idx < PASSES-1: count=SV, pass_idx+1, wrap=1 for that cycle.
  - count == EV and pass_idx == PASSES-1: next state DONE; done=1, busy=0; count holds EV, pass_idx holds PASSES-1; wrap=0.
- DONE: outputs held until start or clr.
- Latency: with no pause, done rises on the (PASSES*(MAX_VAL+1))-th edge after the start edge. Defaults: 24 edges.
- PASSES=1: wrap never asserts.
- MAX_VAL=0: each pass lasts one cycle; wrap asserts every RUN cycle except the last.
- dir changes during RUN have no effect until the next start.
- Arithmetic is WIDTH bits and never exceeds MAX_VAL or goes below 0; no modular wrap past 2**WIDTH-1.
- Reset asserted mid-run: immediate return to IDLE values; no pulse on done or wrap.
- Elaboration check: fail if MAX_VAL >= 2**WIDTH, PASSES < 1, or 2**PASS_W < PASSES.

Decomposition:
- Shared package counter_pkg holds:
  - the state encoding (IDLE=0, RUN=1, DONE=2, 2-bit);
  - direction constants DIR_UP=0 and DIR_DN=1.
- One natural sub-module: step_counter.
  - WIDTH/MAX_VAL bounded up/down counter with load (SV), enable, and an at-end flag.
  - The top level keeps the FSM, the pass counter and the wrap/done logic.

Test Plan:
1. Defaults, dir=0, start for 1 cycle -> count 0..7 three times; wrap high at edges 8 and 16 (pass_idx 1, 2); done=1 and count=7 at edge 24; busy low from edge 24.
2. Defaults, dir=1 -> count 7..0 three times; done at edge 24 with count=0, pass_idx=2.
3. pause high for 5 cycles at count=3, pass 1 -> count/pass frozen, wrap=0; done delayed to edge 29.
4. clr at edge 10; separately, start and clr together in IDLE -> IDLE with count=0, pass_idx=0, done=0; the simultaneous case stays in IDLE.
5. rst pulled low mid-run (count=5, pass 2), asynchronous to clk -> outputs zero immediately without a clock edge; start after release restarts from SV.
6. WIDTH=4, MAX_VAL=9, PASSES=1 -> count 0..9, no wrap, done at edge 10; start while in DONE reruns with done cleared on the start edge.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and direction constants for multi_pass_counter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - bounded up/down counter with load, enable and at-end flag
module step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Saturating steps: never past MAX_VAL going up, never below 0 going down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count < MAX_V) count <= count + ONE;
      end else begin
        if (count != '0) count <= count - ONE;
      end
    end
  end

  assign at_end = (dir == DIR_UP) ? (count == MAX_V) : (count == '0);

endmodule

// File: rtl/multi_pass_counter.sv
// rtl/multi_pass_counter.sv - multi-pass sequence counter: FSM, pass counter, wrap/done flags
module multi_pass_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 7,
  parameter int PASSES  = 3,
  parameter int PASS_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic              pause,
  input  logic              dir,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass_idx,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  if (MAX_VAL >= (1 << WIDTH) || PASSES < 1 || (1 << PASS_W) < PASSES) begin : g_param_check
    $error("multi_pass_counter: illegal WIDTH/MAX_VAL/PASSES/PASS_W combination");
  end

  localparam logic [WIDTH-1:0]  MAX_V     = WIDTH'(MAX_VAL);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

  state_t              state, state_d;
  logic                dir_q, dir_d;
  logic [PASS_W-1:0]   pass_d;
  logic                wrap_d, busy_d, done_d;
  logic                cnt_load, cnt_en, at_end;
  logic [WIDTH-1:0]    load_val;

  step_counter #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (cnt_load),
    .en       (cnt_en),
    .dir      (dir_q),
    .load_val (load_val),
    .count    (count),
    .at_end   (at_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dir_q    <= DIR_UP;
      pass_idx <= '0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      dir_q    <= dir_d;
      pass_idx <= pass_d;
      wrap     <= wrap_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    dir_d    = dir_q;
    pass_d   = pass_idx;
    wrap_d   = 1'b0;
    busy_d   = busy;
    done_d   = done;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    load_val = (dir_q == DIR_DN) ? MAX_V : '0;
    if (clr) begin
      state_d = IDLE;
      pass_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // The start value comes from the live dir input, not the old latch.
            dir_d    = dir;
            cnt_load = 1'b1;
            load_val = (dir == DIR_DN) ? MAX_V : '0;
            pass_d   = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            if (!at_end) begin
              cnt_en = 1'b1;
            end else if (pass_idx < LAST_PASS) begin
              cnt_load = 1'b1;
              pass_d   = pass_idx + PASS_ONE;
              wrap_d   = 1'b1;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pass_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

endmodule
